// File: rtl/spi_fifo_param.sv
// spi_fifo_param: parametrised single-clock FIFO for the SPI TX/RX data paths.
// Show-ahead head output, registered occupancy level, almost-full/almost-empty
// watermarks. Define SPI_FIFO_ERR_EN to add sticky overflow/underflow flags.
module spi_fifo_param #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned AF_LVL = 6,
   parameter int unsigned AE_LVL = 1
) (
   input  logic              clk_i,
   input  logic              rstb_i,
   input  logic              fifo_clr_i,
   input  logic              write_i,
   input  logic [DATA_W-1:0] din_i,
   input  logic              read_i,
   output logic [DATA_W-1:0] dout_o,
   output logic              fifo_full_o,
   output logic              fifo_empty_o,
   output logic              fifo_afull_o,
   output logic              fifo_aempty_o,
`ifdef SPI_FIFO_ERR_EN
   output logic              fifo_ovf_o,
   output logic              fifo_udf_o,
`endif
   output logic [ADDR_W:0]   fifo_level_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned PTR_W = ADDR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr, level;
   logic [PTR_W-1:0]  wr_ptr_nxt, rd_ptr_nxt;
   logic              full, empty, wr_en, rd_en;

   // Flags decoded from the registered pointers and level
   always_comb begin
      empty = (wr_ptr == rd_ptr);
      full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
              (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
      fifo_full_o   = full;
      fifo_empty_o  = empty;
      fifo_afull_o  = (level >= PTR_W'(AF_LVL));
      fifo_aempty_o = (level <= PTR_W'(AE_LVL));
      fifo_level_o  = level;
      dout_o        = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
   end

   // Strobe acceptance uses start-of-cycle flags; clear overrides both strobes
   always_comb begin
      wr_en      = write_i && !full  && !fifo_clr_i;
      rd_en      = read_i  && !empty && !fifo_clr_i;
      wr_ptr_nxt = wr_ptr + PTR_W'(wr_en);
      rd_ptr_nxt = rd_ptr + PTR_W'(rd_en);
      if (fifo_clr_i) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
      end
   end

   // Pointer and level registers
   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         level  <= wr_ptr_nxt - rd_ptr_nxt;
      end
   end

   // Storage array, intentionally not reset
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= din_i;
   end

`ifdef SPI_FIFO_ERR_EN
   // Sticky error flags, cleared only by fifo_clr_i or reset
   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) begin
         fifo_ovf_o <= 1'b0;
         fifo_udf_o <= 1'b0;
      end else if (fifo_clr_i) begin
         fifo_ovf_o <= 1'b0;
         fifo_udf_o <= 1'b0;
      end else begin
         if (write_i && full)  fifo_ovf_o <= 1'b1;
         if (read_i  && empty) fifo_udf_o <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_spi_fifo_param.sv
// Directed self-checking bench for spi_fifo_param (DATA_W=8, ADDR_W=3, AF=6, AE=1).
module tb_spi_fifo_param;

   logic       clk_i = 1'b0;
   logic       rstb_i = 1'b0;
   logic       fifo_clr_i = 1'b0;
   logic       write_i = 1'b0;
   logic [7:0] din_i = 8'h00;
   logic       read_i = 1'b0;
   logic [7:0] dout_o;
   logic       fifo_full_o, fifo_empty_o, fifo_afull_o, fifo_aempty_o;
   logic [3:0] fifo_level_o;
`ifdef SPI_FIFO_ERR_EN
   logic       fifo_ovf_o, fifo_udf_o;
`endif

   int checks = 0;
   int errors = 0;

   spi_fifo_param #(.DATA_W(8), .ADDR_W(3), .AF_LVL(6), .AE_LVL(1)) dut (
      .clk_i(clk_i), .rstb_i(rstb_i), .fifo_clr_i(fifo_clr_i),
      .write_i(write_i), .din_i(din_i), .read_i(read_i), .dout_o(dout_o),
      .fifo_full_o(fifo_full_o), .fifo_empty_o(fifo_empty_o),
      .fifo_afull_o(fifo_afull_o), .fifo_aempty_o(fifo_aempty_o),
`ifdef SPI_FIFO_ERR_EN
      .fifo_ovf_o(fifo_ovf_o), .fifo_udf_o(fifo_udf_o),
`endif
      .fifo_level_o(fifo_level_o)
   );

   always #5 clk_i = ~clk_i;

   // Advance one clock edge, leaving time to sample and drive away from it
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      write_i = 1'b0; read_i = 1'b0; fifo_clr_i = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      write_i = 1'b1; din_i = d; read_i = 1'b0;
      step();
      idle();
   endtask

   task automatic test_reset();
      rstb_i = 1'b0; idle();
      #2;
      checks++; if (dout_o !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h exp 00", dout_o); end
      checks++; if (fifo_empty_o !== 1'b1 || fifo_full_o !== 1'b0) begin errors++; $display("FAIL reset_empty_full: got %b%b exp 10", fifo_empty_o, fifo_full_o); end
      checks++; if (fifo_afull_o !== 1'b0 || fifo_aempty_o !== 1'b1) begin errors++; $display("FAIL reset_af_ae: got %b%b exp 01", fifo_afull_o, fifo_aempty_o); end
      checks++; if (fifo_level_o !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", fifo_level_o); end
`ifdef SPI_FIFO_ERR_EN
      checks++; if (fifo_ovf_o !== 1'b0 || fifo_udf_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b%b exp 00", fifo_ovf_o, fifo_udf_o); end
`endif
      step();
      rstb_i = 1'b1;
      step();
   endtask

   task automatic test_fill();
      for (int k = 1; k <= 8; k++) begin
         push(8'(k));
         checks++; if (fifo_level_o !== 4'(k)) begin errors++; $display("FAIL fill_level: got %0d exp %0d", fifo_level_o, k); end
         checks++; if (fifo_afull_o !== (k >= 6)) begin errors++; $display("FAIL fill_afull: level %0d got %b exp %b", k, fifo_afull_o, (k >= 6)); end
         checks++; if (fifo_aempty_o !== (k <= 1)) begin errors++; $display("FAIL fill_aempty: level %0d got %b exp %b", k, fifo_aempty_o, (k <= 1)); end
         checks++; if (dout_o !== 8'h01 || fifo_empty_o !== 1'b0) begin errors++; $display("FAIL fill_head: got %h/%b exp 01/0", dout_o, fifo_empty_o); end
      end
      checks++; if (fifo_full_o !== 1'b1) begin errors++; $display("FAIL fill_full: got %b exp 1", fifo_full_o); end
      for (int k = 1; k <= 8; k++) begin
         checks++; if (dout_o !== 8'(k)) begin errors++; $display("FAIL read_data: got %h exp %h", dout_o, 8'(k)); end
         read_i = 1'b1; step(); idle();
         checks++; if (fifo_level_o !== 4'(8 - k)) begin errors++; $display("FAIL read_level: got %0d exp %0d", fifo_level_o, 8 - k); end
      end
      checks++; if (fifo_empty_o !== 1'b1 || dout_o !== 8'h00) begin errors++; $display("FAIL read_empty: got %b/%h exp 1/00", fifo_empty_o, dout_o); end
   endtask

   task automatic test_overflow();
      for (int k = 1; k <= 8; k++) push(8'(k));
      push(8'hAA);
      checks++; if (fifo_level_o !== 4'd8 || dout_o !== 8'h01) begin errors++; $display("FAIL ovf_hold: got %0d/%h exp 8/01", fifo_level_o, dout_o); end
`ifdef SPI_FIFO_ERR_EN
      checks++; if (fifo_ovf_o !== 1'b1 || fifo_udf_o !== 1'b0) begin errors++; $display("FAIL ovf_flag: got %b%b exp 10", fifo_ovf_o, fifo_udf_o); end
`endif
      for (int k = 1; k <= 8; k++) begin
         checks++; if (dout_o !== 8'(k)) begin errors++; $display("FAIL ovf_drain: got %h exp %h", dout_o, 8'(k)); end
         read_i = 1'b1; step(); idle();
      end
      read_i = 1'b1; step(); idle();
      checks++; if (fifo_level_o !== 4'd0 || dout_o !== 8'h00 || fifo_empty_o !== 1'b1) begin errors++; $display("FAIL udf_hold: got %0d/%h/%b exp 0/00/1", fifo_level_o, dout_o, fifo_empty_o); end
`ifdef SPI_FIFO_ERR_EN
      checks++; if (fifo_udf_o !== 1'b1 || fifo_ovf_o !== 1'b1) begin errors++; $display("FAIL udf_flag: got %b%b exp 11", fifo_ovf_o, fifo_udf_o); end
`endif
      fifo_clr_i = 1'b1; step(); idle();
   endtask

   task automatic test_simultaneous();
      for (int k = 0; k < 8; k++) push(8'h10 + 8'(k));
      write_i = 1'b1; read_i = 1'b1; din_i = 8'h55; step(); idle();
      checks++; if (fifo_level_o !== 4'd7 || dout_o !== 8'h11) begin errors++; $display("FAIL sim_full: got %0d/%h exp 7/11", fifo_level_o, dout_o); end
      for (int k = 1; k < 8; k++) begin
         checks++; if (dout_o !== 8'h10 + 8'(k)) begin errors++; $display("FAIL sim_full_drain: got %h exp %h", dout_o, 8'h10 + 8'(k)); end
         read_i = 1'b1; step(); idle();
      end
      checks++; if (fifo_empty_o !== 1'b1) begin errors++; $display("FAIL sim_no55: empty got %b exp 1", fifo_empty_o); end
      write_i = 1'b1; read_i = 1'b1; din_i = 8'h66; step(); idle();
      checks++; if (fifo_level_o !== 4'd1 || dout_o !== 8'h66) begin errors++; $display("FAIL sim_empty: got %0d/%h exp 1/66", fifo_level_o, dout_o); end
      push(8'h67); push(8'h68);
      write_i = 1'b1; read_i = 1'b1; din_i = 8'h69; step(); idle();
      checks++; if (fifo_level_o !== 4'd3 || dout_o !== 8'h67) begin errors++; $display("FAIL sim_mid: got %0d/%h exp 3/67", fifo_level_o, dout_o); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (dout_o !== 8'h67 + 8'(k)) begin errors++; $display("FAIL sim_mid_drain: got %h exp %h", dout_o, 8'h67 + 8'(k)); end
         read_i = 1'b1; step(); idle();
      end
   endtask

   task automatic test_wrap();
      push(8'hA0); push(8'hA1);
      for (int i = 0; i < 20; i++) begin
         write_i = 1'b1; read_i = 1'b1; din_i = 8'hA2 + 8'(i); step(); idle();
         checks++; if (fifo_level_o !== 4'd2 || dout_o !== 8'hA1 + 8'(i)) begin errors++; $display("FAIL wrap_pair%0d: got %0d/%h exp 2/%h", i, fifo_level_o, dout_o, 8'hA1 + 8'(i)); end
      end
      checks++; if (dout_o !== 8'hB4) begin errors++; $display("FAIL wrap_tail0: got %h exp b4", dout_o); end
      read_i = 1'b1; step(); idle();
      checks++; if (dout_o !== 8'hB5) begin errors++; $display("FAIL wrap_tail1: got %h exp b5", dout_o); end
      read_i = 1'b1; step(); idle();
      checks++; if (fifo_empty_o !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b exp 1", fifo_empty_o); end
   endtask

   task automatic test_clear();
      read_i = 1'b1; step(); idle();
      for (int k = 0; k < 8; k++) push(8'h30 + 8'(k));
      push(8'hEE);
      for (int k = 0; k < 3; k++) begin read_i = 1'b1; step(); idle(); end
      checks++; if (fifo_level_o !== 4'd5 || dout_o !== 8'h33) begin errors++; $display("FAIL clr_pre: got %0d/%h exp 5/33", fifo_level_o, dout_o); end
`ifdef SPI_FIFO_ERR_EN
      checks++; if (fifo_ovf_o !== 1'b1 || fifo_udf_o !== 1'b1) begin errors++; $display("FAIL clr_pre_err: got %b%b exp 11", fifo_ovf_o, fifo_udf_o); end
`endif
      fifo_clr_i = 1'b1; write_i = 1'b1; din_i = 8'h77; step(); idle();
      checks++; if (fifo_level_o !== 4'd0 || fifo_empty_o !== 1'b1 || fifo_aempty_o !== 1'b1) begin errors++; $display("FAIL clr_state: got %0d/%b/%b exp 0/1/1", fifo_level_o, fifo_empty_o, fifo_aempty_o); end
      checks++; if (dout_o !== 8'h00 || fifo_full_o !== 1'b0 || fifo_afull_o !== 1'b0) begin errors++; $display("FAIL clr_out: got %h/%b/%b exp 00/0/0", dout_o, fifo_full_o, fifo_afull_o); end
`ifdef SPI_FIFO_ERR_EN
      checks++; if (fifo_ovf_o !== 1'b0 || fifo_udf_o !== 1'b0) begin errors++; $display("FAIL clr_err: got %b%b exp 00", fifo_ovf_o, fifo_udf_o); end
`endif
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 4; k++) push(8'hC0 + 8'(k));
      checks++; if (fifo_level_o !== 4'd4 || dout_o !== 8'hC0) begin errors++; $display("FAIL ar_pre: got %0d/%h exp 4/c0", fifo_level_o, dout_o); end
      #3 rstb_i = 1'b0;
      #1;
      checks++; if (fifo_level_o !== 4'd0 || dout_o !== 8'h00) begin errors++; $display("FAIL ar_level_dout: got %0d/%h exp 0/00", fifo_level_o, dout_o); end
      checks++; if (fifo_empty_o !== 1'b1 || fifo_full_o !== 1'b0 || fifo_afull_o !== 1'b0 || fifo_aempty_o !== 1'b1) begin errors++; $display("FAIL ar_flags: got e%b f%b af%b ae%b exp e1 f0 af0 ae1", fifo_empty_o, fifo_full_o, fifo_afull_o, fifo_aempty_o); end
`ifdef SPI_FIFO_ERR_EN
      checks++; if (fifo_ovf_o !== 1'b0 || fifo_udf_o !== 1'b0) begin errors++; $display("FAIL ar_err: got %b%b exp 00", fifo_ovf_o, fifo_udf_o); end
`endif
      #2 rstb_i = 1'b1;
      step();
      checks++; if (fifo_level_o !== 4'd0 || fifo_empty_o !== 1'b1) begin errors++; $display("FAIL ar_post: got %0d/%b exp 0/1", fifo_level_o, fifo_empty_o); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_simultaneous();
      test_wrap();
      test_clear();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
